alu_share_arbiter: RTL and testbench

Sequences one shared combinational ALU between two requesters (port 0: core execute stage, port 1: auxiliary address/compare unit). Accepts one operation at a time, registers its operands and opcode fields, drives them into the ALU for one cycle, captures the result, and returns it on the requester's response port. Arbitration is round-robin by default, and each response is held until the requester accepts it.

---
 rtl/alu_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Purpose: shares one combinational ALU between two requesters (exec stage, aux unit).
// Latency: 2 cycles from request accept to response valid; one operation in flight.
// Backpressure: response held stable until rspN_ready; new requests stall meanwhile.
module alu_share_arbiter #(
  parameter int XLEN       = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_op1,
  input  logic [XLEN-1:0] req0_op2,
  input  logic [2:0]      req0_funct3,
  input  logic [6:0]      req0_funct7,
  input  logic [4:0]      req0_shamt,
  input  logic [2:0]      req0_insn_type,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_op1,
  input  logic [XLEN-1:0] req1_op2,
  input  logic [2:0]      req1_funct3,
  input  logic [6:0]      req1_funct7,
  input  logic [4:0]      req1_shamt,
  input  logic [2:0]      req1_insn_type,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  output logic [4:0]      alu_shamt,
  output logic [2:0]      alu_insn_type,
  input  logic [XLEN-1:0] alu_result,
  output logic            rsp0_valid,
  output logic [XLEN-1:0] rsp0_data,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  output logic [XLEN-1:0] rsp1_data,
  input  logic            rsp1_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            last_grant;
  logic            owner;
  logic            grant;
  logic            grant_vld;
  logic            accept;
  logic [XLEN-1:0] op1_q, op2_q, result_q;
  logic [2:0]      funct3_q, insn_type_q;
  logic [6:0]      funct7_q;
  logic [4:0]      shamt_q;

  // Pick the port to serve: a lone requester wins, ties go by priority mode.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = FIXED_PRIO ? 1'b0 : ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Next-state and handshake outputs; only IDLE can accept a request.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req0_ready = ~grant;
          req1_ready = grant;
          accept     = 1'b1;
          state_nxt  = BUSY;
        end
      end
      BUSY: state_nxt = RESP;
      RESP: begin
        if (owner ? rsp1_ready : rsp0_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture on accept, result capture at the end of the BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      shamt_q     <= '0;
      insn_type_q <= '0;
      result_q    <= '0;
    end else begin
      if (accept) begin
        owner       <= grant;
        last_grant  <= grant;
        op1_q       <= grant ? req1_op1       : req0_op1;
        op2_q       <= grant ? req1_op2       : req0_op2;
        funct3_q    <= grant ? req1_funct3    : req0_funct3;
        funct7_q    <= grant ? req1_funct7    : req0_funct7;
        shamt_q     <= grant ? req1_shamt     : req0_shamt;
        insn_type_q <= grant ? req1_insn_type : req0_insn_type;
      end
      if (state == BUSY) begin
        result_q <= alu_result;
      end
    end
  end

  // Outside BUSY the ALU sees an invalid type so it produces 0.
  assign alu_op1       = op1_q;
  assign alu_op2       = op2_q;
  assign alu_funct3    = funct3_q;
  assign alu_funct7    = funct7_q;
  assign alu_shamt     = shamt_q;
  assign alu_insn_type = (state == BUSY) ? insn_type_q : 3'b111;

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign rsp0_data  = result_q;
  assign rsp1_data  = result_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose: scoreboard bench for alu_share_arbiter (round-robin and fixed-priority instances).
// Latency: expects response 2 cycles after accept.
// Backpressure: exercises held responses and stalled requests.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        rv    [2];
  logic        rdy   [2];
  logic [31:0] r_op1 [2];
  logic [31:0] r_op2 [2];
  logic [2:0]  r_f3  [2];
  logic [6:0]  r_f7  [2];
  logic [4:0]  r_sh  [2];
  logic [2:0]  r_ty  [2];
  logic        rsp_v [2];
  logic [31:0] rsp_d [2];
  logic        rsp_r [2];
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [2:0]  alu_funct3, alu_insn_type;
  logic [6:0]  alu_funct7;
  logic [4:0]  alu_shamt;

  logic        fv     [2];
  logic        frdy   [2];
  logic        frsp_v [2];
  logic [31:0] frsp_d [2];
  logic        frsp_r [2];
  logic [31:0] fa_op1, fa_op2, fa_result;
  logic [2:0]  fa_funct3, fa_insn_type;
  logic [6:0]  fa_funct7;
  logic [4:0]  fa_shamt;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int          grant_log [$];
  bit          acc0, acc1, hs0, hs1, any_rsp1;

  always #5 clk = ~clk;

  // Stand-in for the shared RV32 ALU.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [4:0] sh, input logic [2:0] ty);
    logic [31:0] r;
    logic [4:0]  s;
    r = '0;
    s = (ty == 3'b000) ? sh : b[4:0];
    if (ty == 3'b000 || ty == 3'b001) begin
      case (f3)
        3'b000: r = (ty == 3'b001 && f7[5]) ? a - b : a + b;
        3'b001: r = a << s;
        3'b010: r = {31'b0, ($signed(a) < $signed(b))};
        3'b011: r = {31'b0, (a < b)};
        3'b100: r = a ^ b;
        3'b101: r = f7[5] ? 32'($signed(a) >>> s) : a >> s;
        3'b110: r = a | b;
        default: r = a & b;
      endcase
    end
    return r;
  endfunction

  assign alu_result = alu_model(alu_op1, alu_op2, alu_funct3, alu_funct7, alu_shamt, alu_insn_type);
  assign fa_result  = alu_model(fa_op1, fa_op2, fa_funct3, fa_funct7, fa_shamt, fa_insn_type);

  alu_share_arbiter #(.XLEN(32), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(rv[0]), .req0_ready(rdy[0]), .req0_op1(r_op1[0]), .req0_op2(r_op2[0]),
    .req0_funct3(r_f3[0]), .req0_funct7(r_f7[0]), .req0_shamt(r_sh[0]), .req0_insn_type(r_ty[0]),
    .req1_valid(rv[1]), .req1_ready(rdy[1]), .req1_op1(r_op1[1]), .req1_op2(r_op2[1]),
    .req1_funct3(r_f3[1]), .req1_funct7(r_f7[1]), .req1_shamt(r_sh[1]), .req1_insn_type(r_ty[1]),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_shamt(alu_shamt), .alu_insn_type(alu_insn_type), .alu_result(alu_result),
    .rsp0_valid(rsp_v[0]), .rsp0_data(rsp_d[0]), .rsp0_ready(rsp_r[0]),
    .rsp1_valid(rsp_v[1]), .rsp1_data(rsp_d[1]), .rsp1_ready(rsp_r[1])
  );

  alu_share_arbiter #(.XLEN(32), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(fv[0]), .req0_ready(frdy[0]), .req0_op1(r_op1[0]), .req0_op2(r_op2[0]),
    .req0_funct3(r_f3[0]), .req0_funct7(r_f7[0]), .req0_shamt(r_sh[0]), .req0_insn_type(r_ty[0]),
    .req1_valid(fv[1]), .req1_ready(frdy[1]), .req1_op1(r_op1[1]), .req1_op2(r_op2[1]),
    .req1_funct3(r_f3[1]), .req1_funct7(r_f7[1]), .req1_shamt(r_sh[1]), .req1_insn_type(r_ty[1]),
    .alu_op1(fa_op1), .alu_op2(fa_op2), .alu_funct3(fa_funct3), .alu_funct7(fa_funct7),
    .alu_shamt(fa_shamt), .alu_insn_type(fa_insn_type), .alu_result(fa_result),
    .rsp0_valid(frsp_v[0]), .rsp0_data(frsp_d[0]), .rsp0_ready(frsp_r[0]),
    .rsp1_valid(frsp_v[1]), .rsp1_data(frsp_d[1]), .rsp1_ready(frsp_r[1])
  );

  // One clock: observe handshakes at negedge, score responses, drop accepted valids after the edge.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    acc0 = rv[0] && rdy[0];
    acc1 = rv[1] && rdy[1];
    if (acc0) grant_log.push_back(0);
    if (acc1) grant_log.push_back(1);
    hs0 = rsp_v[0] && rsp_r[0];
    hs1 = rsp_v[1] && rsp_r[1];
    if (rsp_v[1]) any_rsp1 = 1'b1;
    if (hs0) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL rsp0_unexpected: got data %h, required no response", rsp_d[0]);
      end else begin
        e = q0.pop_front();
        if (rsp_d[0] !== e) begin
          n_fail++;
          $display("FAIL rsp0_data: got %h, required %h", rsp_d[0], e);
        end
      end
    end
    if (hs1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL rsp1_unexpected: got data %h, required no response", rsp_d[1]);
      end else begin
        e = q1.pop_front();
        if (rsp_d[1] !== e) begin
          n_fail++;
          $display("FAIL rsp1_data: got %h, required %h", rsp_d[1], e);
        end
      end
    end
    @(posedge clk);
    #1;
    if (acc0) rv[0] = 1'b0;
    if (acc1) rv[1] = 1'b0;
  endtask

  // Present a request on port p and queue its expected result.
  task automatic load(input int p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] sh, input logic [2:0] ty,
                      input logic [31:0] exp_val);
    r_op1[p] = a;
    r_op2[p] = b;
    r_f3[p]  = f3;
    r_f7[p]  = f7;
    r_sh[p]  = sh;
    r_ty[p]  = ty;
    rv[p]    = 1'b1;
    if (p == 0) q0.push_back(exp_val);
    else        q1.push_back(exp_val);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || rv[0] || rv[1]) && n < 40) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (n >= 40) begin
      n_fail++;
      $display("FAIL drain_timeout: q0=%0d q1=%0d entries left, required 0", q0.size(), q1.size());
    end
  endtask

  task automatic wait_acc(input int p);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!(p == 0 ? acc0 : acc1) && n < 10);
    n_cmp++;
    if (!(p == 0 ? acc0 : acc1)) begin
      n_fail++;
      $display("FAIL accept_timeout: port %0d not accepted in %0d cycles, required accept", p, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_v[0], rsp_v[1]} !== 2'b00) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b%b, required 00", rsp_v[0], rsp_v[1]);
    end
    n_cmp++;
    if (alu_insn_type !== 3'b111) begin
      n_fail++; $display("FAIL reset_alu_type: got %b, required 111", alu_insn_type);
    end
    n_cmp++;
    if ({alu_op1, alu_op2, rsp_d[0]} !== 96'd0) begin
      n_fail++; $display("FAIL reset_regs: op1=%h op2=%h data=%h, required 0", alu_op1, alu_op2, rsp_d[0]);
    end
    n_cmp++;
    if ({rdy[0], rdy[1]} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b%b, required 00", rdy[0], rdy[1]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_tie();
    grant_log.delete();
    load(0, 32'd10, 32'd3, 3'b000, 7'b0100000, 5'd0, 3'b001, 32'd7);
    load(1, 32'hF0, 32'h0F, 3'b100, 7'd0, 5'd0, 3'b001, 32'hFF);
    cycle();
    n_cmp++;
    if ({acc0, acc1} !== 2'b10) begin
      n_fail++; $display("FAIL tie_first_grant: accepts %b%b, required 10", acc0, acc1);
    end
    drain();
    n_cmp++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
      n_fail++; $display("FAIL tie_order: got %p, required 0,1", grant_log);
    end
  endtask

  task automatic test_fairness();
    int n0 = 1, n1 = 1, k = 0;
    int exp_g [4] = '{0, 1, 0, 1};
    grant_log.delete();
    load(0, 32'd1, 32'd2, 3'b000, 7'd0, 5'd0, 3'b001, 32'd3);
    load(1, 32'hA0, 32'h05, 3'b110, 7'd0, 5'd0, 3'b001, 32'hA5);
    while ((n0 < 2 || n1 < 2) && k < 40) begin
      cycle();
      k++;
      if (acc0 && n0 < 2) begin
        load(0, 32'd100, 32'd200, 3'b000, 7'd0, 5'd0, 3'b001, 32'd300); n0++;
      end
      if (acc1 && n1 < 2) begin
        load(1, 32'hFF, 32'h0F, 3'b111, 7'd0, 5'd0, 3'b001, 32'h0F); n1++;
      end
    end
    drain();
    n_cmp++;
    if (grant_log.size() != 4) begin
      n_fail++; $display("FAIL rr_count: got %0d grants, required 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (grant_log[i] != exp_g[i]) begin
          n_fail++; $display("FAIL rr_grant%0d: got port %0d, required %0d", i, grant_log[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    any_rsp1 = 1'b0;
    load(0, 32'd5, 32'd7, 3'b000, 7'd0, 5'd0, 3'b000, 32'd12);
    wait_acc(0);
    n_cmp++;
    if ({alu_op1, alu_op2, alu_insn_type} !== {32'd5, 32'd7, 3'b000}) begin
      n_fail++; $display("FAIL busy_alu_drive: op1=%h op2=%h type=%b, required 5 7 000", alu_op1, alu_op2, alu_insn_type);
    end
    cycle();
    n_cmp++;
    if (hs0 !== 1'b0) begin
      n_fail++; $display("FAIL single_early_rsp: rsp0 at 1 cycle, required at 2");
    end
    cycle();
    n_cmp++;
    if (hs0 !== 1'b1) begin
      n_fail++; $display("FAIL single_latency: rsp0 handshake %b at 2 cycles, required 1", hs0);
    end
    n_cmp++;
    if (any_rsp1 !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp1: rsp1_valid seen %b, required 0", any_rsp1);
    end
    drain();
  endtask

  task automatic test_backpressure();
    rsp_r[1] = 1'b0;
    load(1, 32'h80000000, 32'd0, 3'b101, 7'b0100000, 5'd4, 3'b000, 32'hF8000000);
    wait_acc(1);
    load(0, 32'd1, 32'd1, 3'b000, 7'd0, 5'd0, 3'b000, 32'd2);
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if ({rsp_v[1], rsp_d[1], rdy[0]} !== {1'b1, 32'hF8000000, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b data=%h req0_ready=%b, required 1 f8000000 0", i, rsp_v[1], rsp_d[1], rdy[0]);
      end
    end
    rsp_r[1] = 1'b1;
    cycle();
    n_cmp++;
    if ({hs1, acc0} !== 2'b10) begin
      n_fail++; $display("FAIL bp_release: rsp1 hs=%b req0 acc=%b, required 1 0", hs1, acc0);
    end
    n_cmp++;
    if (rdy[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_req0_ready: got %b, required 1", rdy[0]);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [31:0] dropped;
    load(0, 32'd9, 32'd9, 3'b000, 7'd0, 5'd0, 3'b001, 32'd18);
    wait_acc(0);
    n_cmp++;
    if (alu_insn_type !== 3'b001) begin
      n_fail++; $display("FAIL mid_busy_type: got %b, required 001", alu_insn_type);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    dropped = q0.pop_back();
    n_cmp++;
    if ({rsp_v[0], rsp_v[1], alu_insn_type} !== 5'b00111) begin
      n_fail++; $display("FAIL mid_reset_state: rsp_v=%b%b type=%b, required 00 111", rsp_v[0], rsp_v[1], alu_insn_type);
    end
    repeat (3) cycle();
    load(0, 32'd1, 32'd2, 3'b011, 7'd0, 5'd0, 3'b001, 32'd1);
    drain();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({alu_insn_type, rsp_v[0], rsp_v[1]} !== 5'b11100) begin
        n_fail++; $display("FAIL idle_quiet%0d: type=%b rsp_v=%b%b, required 111 00", i, alu_insn_type, rsp_v[0], rsp_v[1]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fixed_prio();
    int got = 0, k = 0;
    load(0, 32'd4, 32'd4, 3'b000, 7'd0, 5'd0, 3'b001, 32'd8);
    load(1, 32'd6, 32'd6, 3'b000, 7'd0, 5'd0, 3'b001, 32'd12);
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    q0.delete();
    q1.delete();
    fv[0] = 1'b1;
    fv[1] = 1'b1;
    while (got < 4 && k < 40) begin
      @(negedge clk);
      if ((fv[0] && frdy[0]) || (fv[1] && frdy[1])) begin
        n_cmp++;
        if (frdy[1] !== 1'b0 || frdy[0] !== 1'b1) begin
          n_fail++; $display("FAIL fp_grant%0d: ready=%b%b, required port 0 (10)", got, frdy[0], frdy[1]);
        end
        got++;
      end
      @(posedge clk);
      #1;
      k++;
    end
    fv[0] = 1'b0;
    fv[1] = 1'b0;
    n_cmp++;
    if (got < 4) begin
      n_fail++; $display("FAIL fp_timeout: got %0d grants, required 4", got);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; fv[i] = 1'b0; rsp_r[i] = 1'b1; frsp_r[i] = 1'b1;
      r_op1[i] = '0; r_op2[i] = '0; r_f3[i] = '0; r_f7[i] = '0; r_sh[i] = '0; r_ty[i] = '0;
    end
    test_reset();
    test_tie();
    test_fairness();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_idle();
    test_fixed_prio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
